// File: rtl/calc1_req_driver.sv
// calc1_req_driver
// Drives a single calc1 request port. The block accepts one whole transaction (cmd, op1, op2)
// on an upstream valid/ready interface and sends it onto the calc1 pins over two cycles: cmd
// with op1, then op2. It then waits for the calculator's response and returns the result to
// the upstream side.
//
// Ports
//   c_clk, reset                 rising-edge clock; synchronous active-high reset
//   txn_valid/txn_ready          upstream transaction handshake (txn_cmd, txn_op1, txn_op2)
//   req_cmd_out, req_data_out    registered calc1 request pins
//   out_resp, out_data           calc1 response pins
//   rsp_valid/rsp_ready          upstream result handshake (rsp_code, rsp_data, rsp_timeout)
//   txn_count, err_count         saturating counters: completed transactions and spurious responses
//
// State table
//   state  | meaning
//   IDLE   | bus quiet, txn_ready high, waiting for an upstream transaction
//   OP1    | bus carries cmd + op1 for one cycle
//   OP2    | bus carries cmd=0 + op2 for one cycle
//   WAIT   | bus quiet, timer running, waiting for out_resp != 0
//   DONE   | result presented upstream until rsp_valid && rsp_ready
module calc1_req_driver #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic             c_clk,
   input  logic             reset,
   input  logic             txn_valid,
   output logic             txn_ready,
   input  logic [3:0]       txn_cmd,
   input  logic [31:0]      txn_op1,
   input  logic [31:0]      txn_op2,
   output logic [3:0]       req_cmd_out,
   output logic [31:0]      req_data_out,
   input  logic [1:0]       out_resp,
   input  logic [31:0]      out_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_code,
   output logic [31:0]      rsp_data,
   output logic             rsp_timeout,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_OP1  = 3'd1;
   localparam logic [2:0] S_OP2  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]       r_state;
   logic [TW-1:0]    r_timer;
   logic [31:0]      r_op2;
   logic [3:0]       r_req_cmd;
   logic [31:0]      r_req_data;
   logic             r_rsp_valid;
   logic [1:0]       r_rsp_code;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_timeout;
   logic [CNT_W-1:0] r_txn_count;
   logic [CNT_W-1:0] r_err_count;

   logic w_resp_seen;
   logic w_handshake;

   assign w_resp_seen = (out_resp != 2'd0);
   assign w_handshake = r_rsp_valid && rsp_ready;

   assign txn_ready    = (r_state == S_IDLE) && !reset;
   assign req_cmd_out  = r_req_cmd;
   assign req_data_out = r_req_data;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_code     = r_rsp_code;
   assign rsp_data     = r_rsp_data;
   assign rsp_timeout  = r_rsp_timeout;
   assign txn_count    = r_txn_count;
   assign err_count    = r_err_count;

   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_op2         <= '0;
         r_req_cmd     <= '0;
         r_req_data    <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_code    <= '0;
         r_rsp_data    <= '0;
         r_rsp_timeout <= 1'b0;
         r_txn_count   <= '0;
         r_err_count   <= '0;
      end else begin
         // A response outside WAIT belongs to no transaction; count it and ignore its data.
         if (w_resp_seen && (r_state != S_WAIT) && (r_err_count != '1))
            r_err_count <= r_err_count + CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               r_req_cmd  <= '0;
               r_req_data <= '0;
               if (txn_valid) begin
                  if (txn_cmd != 4'd0) begin
                     // The bus registers are loaded here so that op1 appears in the cycle right after acceptance.
                     r_req_cmd  <= txn_cmd;
                     r_req_data <= txn_op1;
                     r_op2      <= txn_op2;
                     r_state    <= S_OP1;
                  end else begin
                     r_rsp_code    <= '0;
                     r_rsp_data    <= '0;
                     r_rsp_timeout <= 1'b0;
                     r_rsp_valid   <= 1'b1;
                     r_state       <= S_DONE;
                  end
               end
            end
            S_OP1: begin
               r_req_cmd  <= '0;
               r_req_data <= r_op2;
               r_state    <= S_OP2;
            end
            S_OP2: begin
               r_req_cmd  <= '0;
               r_req_data <= '0;
               r_timer    <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               r_req_cmd  <= '0;
               r_req_data <= '0;
               // If a response arrives on the same edge as the timeout, the response is used.
               if (w_resp_seen) begin
                  r_rsp_code    <= out_resp;
                  r_rsp_data    <= out_data;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_DONE;
               end else if (r_timer == TIMER_LAST) begin
                  r_rsp_code    <= '0;
                  r_rsp_data    <= '0;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_DONE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_DONE: begin
               r_req_cmd  <= '0;
               r_req_data <= '0;
               if (w_handshake) begin
                  r_rsp_valid <= 1'b0;
                  if (r_txn_count != '1)
                     r_txn_count <= r_txn_count + CNT_W'(1);
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_req_cmd  <= '0;
               r_req_data <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
